// File: rtl/sw_debounce_sampler_if.sv
// Bundle of the raw switch inputs and the debounced outputs of sw_debounce_sampler.
// The master drives the switches and the enable. The slave (the sampler) drives the clean A..E and the change strobes.
interface sw_debounce_sampler_if;
    logic [4:0] sw;
    logic       en;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       E;
    logic       upd;
    logic [4:0] chg;
    logic       busy;

    modport master (
        output sw,
        output en,
        input  A,
        input  B,
        input  C,
        input  D,
        input  E,
        input  upd,
        input  chg,
        input  busy
    );

    modport slave (
        input  sw,
        input  en,
        output A,
        output B,
        output C,
        output D,
        output E,
        output upd,
        output chg,
        output busy
    );
endinterface

// File: rtl/sw_debounce_sampler.sv
// Debounces five async switch lines into registered A..E, with a one-cycle upd strobe and a chg mask on each commit.
// A stable new level commits 2+DB_CYCLES edges after first sampling; there is no backpressure, and en=0 suspends settling.
module sw_debounce_sampler #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sw_debounce_sampler_if.slave  bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [4:0]       sync1_d, sync1_q;
    logic [4:0]       sync2_d, sync2_q;
    logic [4:0]       out_d,   out_q;
    logic [4:0]       cand_d,  cand_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             upd_d,   upd_q;
    logic [4:0]       chg_d,   chg_q;
    state_t           state_d, state_q;

    logic [4:0] sw_s;
    assign sw_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            chg_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            chg_q   <= chg_d;
            state_q <= state_d;
        end
    end

    // The synchronizer ignores en so that sw_s is already current when sampling resumes.
    always_comb begin
        sync1_d = bus.sw;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        upd_d   = 1'b0;
        chg_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en && (sw_s != out_q)) begin
                    cand_d  = sw_s;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!bus.en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sw_s == out_q) begin
                    // The bounce returned to the committed value, so there is nothing to report.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sw_s != cand_q) begin
                    cand_d = sw_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = cand_q;
                    upd_d   = 1'b1;
                    chg_d   = cand_q ^ out_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.A    = out_q[4];
    assign bus.B    = out_q[3];
    assign bus.C    = out_q[2];
    assign bus.D    = out_q[1];
    assign bus.E    = out_q[0];
    assign bus.upd  = upd_q;
    assign bus.chg  = chg_q;
    assign bus.busy = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_sw_debounce_sampler.sv
// Directed bench for sw_debounce_sampler with DB_CYCLES=4: reset, clean change, bounce, revert, enable, back-to-back and reset mid-settle.
module tb_sw_debounce_sampler;

    logic clk;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    sw_debounce_sampler_if dut_if ();

    sw_debounce_sampler #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    logic [4:0] obs_out;
    assign obs_out = {dut_if.A, dut_if.B, dut_if.C, dut_if.D, dut_if.E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic seen_upd;
    logic seen_busy;

    initial begin
        dut_if.sw = 5'b11111;
        dut_if.en = 1'b1;

        // Asynchronous reset arrives mid-cycle, before the first clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out",  obs_out, 5'b00000);
        chk("rst_upd",  5'(dut_if.upd), 5'd0);
        chk("rst_chg",  dut_if.chg, 5'b00000);
        chk("rst_busy", 5'(dut_if.busy), 5'd0);
        step();
        step();
        rst_n = 1'b1;
        // The next edge is sampling edge 0.
        for (int i = 0; i < 6; i++) step();
        chk("rel_e5_out", obs_out, 5'b00000);
        step();
        chk("rel_e6_out", obs_out, 5'b11111);
        chk("rel_e6_upd", 5'(dut_if.upd), 5'd1);
        chk("rel_e6_chg", dut_if.chg, 5'b11111);

        // Clean change from 00000 to 10100.
        dut_if.sw = 5'b00000;
        do_reset();
        step();
        dut_if.sw = 5'b10100;
        step();
        step();
        chk("clean_e1_busy", 5'(dut_if.busy), 5'd0);
        step();
        chk("clean_e2_busy", 5'(dut_if.busy), 5'd1);
        step();
        step();
        step();
        chk("clean_e5_upd", 5'(dut_if.upd), 5'd0);
        chk("clean_e5_busy", 5'(dut_if.busy), 5'd1);
        step();
        chk("clean_e6_out", obs_out, 5'b10100);
        chk("clean_e6_upd", 5'(dut_if.upd), 5'd1);
        chk("clean_e6_chg", dut_if.chg, 5'b10100);
        step();
        chk("clean_e7_upd", 5'(dut_if.upd), 5'd0);
        chk("clean_e7_chg", dut_if.chg, 5'b00000);
        chk("clean_e7_busy", 5'(dut_if.busy), 5'd0);

        // Bounce on E at edges 0..4 (1,0,1,0,1), then a steady 1; the commit lands at edge 10.
        dut_if.sw = 5'b00000;
        do_reset();
        step();
        seen_upd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) dut_if.sw = (i % 2 == 0) ? 5'b00001 : 5'b00000;
            step();
            seen_upd = seen_upd | dut_if.upd;
        end
        chk("bounce_no_early_upd", 5'(seen_upd), 5'd0);
        step();
        chk("bounce_e10_out", obs_out, 5'b00001);
        chk("bounce_e10_upd", 5'(dut_if.upd), 5'd1);
        chk("bounce_e10_chg", dut_if.chg, 5'b00001);
        step();
        chk("bounce_e11_upd", 5'(dut_if.upd), 5'd0);

        // A three-cycle glitch to 01000 returns to 00000.
        dut_if.sw = 5'b00000;
        do_reset();
        step();
        dut_if.sw = 5'b01000;
        seen_upd = 1'b0;
        step();
        step();
        step();
        chk("revert_e2_busy", 5'(dut_if.busy), 5'd1);
        dut_if.sw = 5'b00000;
        step();
        step();
        chk("revert_e4_busy", 5'(dut_if.busy), 5'd1);
        step();
        chk("revert_e5_busy", 5'(dut_if.busy), 5'd0);
        seen_upd = dut_if.upd;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_upd = seen_upd | dut_if.upd;
        end
        chk("revert_no_upd", 5'(seen_upd), 5'd0);
        chk("revert_out", obs_out, 5'b00000);

        // While en is low, nothing settles; raising en starts SETTLE on the next edge.
        dut_if.en = 1'b0;
        dut_if.sw = 5'b11011;
        seen_upd  = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen_upd  = seen_upd | dut_if.upd;
            seen_busy = seen_busy | dut_if.busy;
        end
        chk("en_off_upd", 5'(seen_upd), 5'd0);
        chk("en_off_busy", 5'(seen_busy), 5'd0);
        chk("en_off_out", obs_out, 5'b00000);
        dut_if.en = 1'b1;
        step();
        chk("en_on_busy", 5'(dut_if.busy), 5'd1);
        step();
        step();
        step();
        chk("en_on_pre_upd", 5'(dut_if.upd), 5'd0);
        step();
        chk("en_on_out", obs_out, 5'b11011);
        chk("en_on_upd", 5'(dut_if.upd), 5'd1);
        chk("en_on_chg", dut_if.chg, 5'b11011);

        // Back-to-back: sw_s moves to 00111 on the commit edge of 11100.
        dut_if.sw = 5'b11100;
        for (int i = 0; i < 5; i++) step();
        dut_if.sw = 5'b00111;
        step();
        step();
        chk("b2b_e6_out", obs_out, 5'b11100);
        chk("b2b_e6_chg", dut_if.chg, 5'b00111);
        step();
        chk("b2b_e7_busy", 5'(dut_if.busy), 5'd1);
        for (int i = 0; i < 4; i++) step();
        chk("b2b_e11_out", obs_out, 5'b00111);
        chk("b2b_e11_upd", 5'(dut_if.upd), 5'd1);
        chk("b2b_e11_chg", dut_if.chg, 5'b11011);

        // Dropping en mid-settle abandons the candidate.
        step();
        dut_if.sw = 5'b11111;
        for (int i = 0; i < 4; i++) step();
        dut_if.en = 1'b0;
        step();
        chk("en_drop_busy", 5'(dut_if.busy), 5'd0);
        seen_upd = dut_if.upd;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_upd = seen_upd | dut_if.upd;
        end
        chk("en_drop_no_upd", 5'(seen_upd), 5'd0);
        chk("en_drop_out", obs_out, 5'b00111);

        // Reset mid-settle with cnt=2, then a fresh settle after release.
        dut_if.en = 1'b1;
        dut_if.sw = 5'b00000;
        do_reset();
        step();
        dut_if.sw = 5'b11111;
        for (int i = 0; i < 5; i++) step();
        chk("mid_busy_before", 5'(dut_if.busy), 5'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", obs_out, 5'b00000);
        chk("mid_rst_busy", 5'(dut_if.busy), 5'd0);
        step();
        rst_n = 1'b1;
        seen_upd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_upd = seen_upd | dut_if.upd;
        end
        chk("mid_no_early_upd", 5'(seen_upd), 5'd0);
        step();
        chk("mid_e6_out", obs_out, 5'b11111);
        chk("mid_e6_upd", 5'(dut_if.upd), 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
